// File: rtl/mod_switch_debounce.sv
// ---------------------------------------------------------------------------
// mod_switch_debounce
// Two-flop synchroniser plus an independent debounce counter per switch bit.
// A bit of sw_out takes a new synchronised level only after that level has
// persisted for DB_COUNT consecutive clocks. Any return to the current output
// level before then discards the count.
//
// Optional feature macro: SWITCH_EDGE_EN
//   defined   -> changed[i] is a registered one-cycle pulse on every update
//                of sw_out[i], in either direction
//   undefined -> changed is tied to zero and no edge registers are built
// ---------------------------------------------------------------------------
module mod_switch_debounce #(
    parameter int WIDTH    = 8,
    parameter int DB_COUNT = 500000,
    parameter int CNT_W    = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] changed
);

    // Count value on which a pending level is accepted.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_COUNT - 1);

    // The per-bit state is implicit: a bit is counting whenever its
    // synchronised input disagrees with its current output.
    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_t;

    logic [WIDTH-1:0] sync0;
    logic [WIDTH-1:0] sync1;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_nxt  [WIDTH];
    logic [WIDTH-1:0] out_nxt;
    state_t           state    [WIDTH];

    // Synchronise, then register debounced outputs and counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values present before this edge.
        if (!rst) begin
            sync0  <= '0;
            sync1  <= '0;
            sw_out <= '0;
            // NOTE: the counters are state, not storage, so they are cleared
            // on reset like any other flop; a stale count would shorten the
            // first debounce interval after release.
            cnt    <= '{default: '0};
        end else begin
            sync0  <= sw_raw;
            sync1  <= sync0;
            sw_out <= out_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // Decode each bit's state from the sync1 / sw_out comparison.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            state[i] = (sync1[i] == sw_out[i]) ? ST_STABLE : ST_COUNTING;
        end
    end

    // Next counter and output per bit; accept the new level at count LAST.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        out_nxt = sw_out;
        cnt_nxt = '{default: '0};
        for (int i = 0; i < WIDTH; i++) begin
            case (state[i])
                ST_STABLE: begin
                    cnt_nxt[i] = '0;
                end
                ST_COUNTING: begin
                    if (cnt[i] == LAST) begin
                        out_nxt[i] = sync1[i];
                        cnt_nxt[i] = '0;
                    end else begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                default: begin
                    cnt_nxt[i] = '0;
                end
            endcase
        end
    end

`ifdef SWITCH_EDGE_EN
    // Pulse changed[i] on the same edge that sw_out[i] takes a new value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            changed <= '0;
        end else begin
            changed <= out_nxt ^ sw_out;
        end
    end
`else
    assign changed = '0;
`endif

endmodule
